regfile: RTL and testbench

- Architectural register file with rename tags for the out-of-order core; the consumer end of the reorder buffer's commit and dependency-tag interface.
- Holds 32 x 32-bit registers and, per register, an optional pending-producer ROB tag.
- Applies ROB commits and decoder rename requests.
- Answers decoder operand lookups. It resolves tags against ROB-held results through the ROB query port.

---
 rtl/regfile.sv | 112 +++++++++++
 tb/tb_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Architectural register file with per-register ROB rename tags.
// Applies ROB commits and decoder renames; answers operand lookups with tag/ROB bypass.
module regfile #(
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rob_clear,
  input  logic                 is_commit,
  input  logic [4:0]           set_id,
  input  logic [31:0]          set_val,
  input  logic [ROB_IDX_W-1:0] set_from_rob_id,
  input  logic [4:0]           set_dep_id,
  input  logic [ROB_IDX_W-1:0] set_dep_Q,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  output logic [31:0]          rs1_val,
  output logic                 rs1_has_dep,
  output logic [ROB_IDX_W-1:0] rs1_dep,
  output logic [31:0]          rs2_val,
  output logic                 rs2_has_dep,
  output logic [ROB_IDX_W-1:0] rs2_dep,
  output logic [ROB_IDX_W-1:0] get_rob_id_1,
  input  logic                 rob_avail_1,
  input  logic [31:0]          rob_val_1,
  output logic [ROB_IDX_W-1:0] get_rob_id_2,
  input  logic                 rob_avail_2,
  input  logic [31:0]          rob_val_2
);

  logic [31:0]          val_q [32];
  logic [31:0]          val_d [32];
  logic [ROB_IDX_W-1:0] tag_q [32];
  logic [ROB_IDX_W-1:0] tag_d [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;

  // A flush drops all pending tags and discards the ROB's stale head outputs.
  // Rename is applied after commit so a same-cycle rename of the same register wins.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rob_clear) begin
      busy_d = '0;
    end else begin
      if (is_commit && (set_id != 5'd0)) begin
        val_d[set_id] = set_val;
        if (tag_q[set_id] == set_from_rob_id) busy_d[set_id] = 1'b0;
      end
      if (set_dep_id != 5'd0) begin
        busy_d[set_dep_id] = 1'b1;
        tag_d[set_dep_id]  = set_dep_Q;
      end
    end
  end

  // rdy_in low freezes every register; the read path below stays live.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < 32; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int r = 0; r < 32; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
    end
  end

  always_comb begin
    get_rob_id_1 = tag_q[rs1_id];
    rs1_dep      = tag_q[rs1_id];
    rs1_val      = '0;
    rs1_has_dep  = 1'b0;
    if (rs1_id != 5'd0) begin
      if (!busy_q[rs1_id]) begin
        rs1_val = val_q[rs1_id];
      end else if (is_commit && (set_id == rs1_id) && (set_from_rob_id == tag_q[rs1_id])) begin
        rs1_val = set_val;
      end else if (rob_avail_1) begin
        rs1_val = rob_val_1;
      end else begin
        rs1_has_dep = 1'b1;
      end
    end
  end

  always_comb begin
    get_rob_id_2 = tag_q[rs2_id];
    rs2_dep      = tag_q[rs2_id];
    rs2_val      = '0;
    rs2_has_dep  = 1'b0;
    if (rs2_id != 5'd0) begin
      if (!busy_q[rs2_id]) begin
        rs2_val = val_q[rs2_id];
      end else if (is_commit && (set_id == rs2_id) && (set_from_rob_id == tag_q[rs2_id])) begin
        rs2_val = set_val;
      end else if (rob_avail_2) begin
        rs2_val = rob_val_2;
      end else begin
        rs2_has_dep = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: drivers push expected operand reads into a queue,
// a negedge monitor pops and compares them against the live read ports.
module tb_regfile;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_clear;
  logic          is_commit;
  logic [4:0]    set_id;
  logic [31:0]   set_val;
  logic [RW-1:0] set_from_rob_id;
  logic [4:0]    set_dep_id;
  logic [RW-1:0] set_dep_Q;
  logic [4:0]    rs1_id;
  logic [4:0]    rs2_id;
  logic [31:0]   rs1_val;
  logic          rs1_has_dep;
  logic [RW-1:0] rs1_dep;
  logic [31:0]   rs2_val;
  logic          rs2_has_dep;
  logic [RW-1:0] rs2_dep;
  logic [RW-1:0] get_rob_id_1;
  logic          rob_avail_1;
  logic [31:0]   rob_val_1;
  logic [RW-1:0] get_rob_id_2;
  logic          rob_avail_2;
  logic [31:0]   rob_val_2;

  int checks = 0;
  int errors = 0;

  // entry: {operand, check_tag, val[31:0], has_dep, dep[RW-1:0]}
  logic [RW+34:0] exp_q[$];

  regfile #(.ROB_IDX_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_commit(is_commit), .set_id(set_id), .set_val(set_val),
    .set_from_rob_id(set_from_rob_id), .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs1_has_dep(rs1_has_dep), .rs1_dep(rs1_dep),
    .rs2_val(rs2_val), .rs2_has_dep(rs2_has_dep), .rs2_dep(rs2_dep),
    .get_rob_id_1(get_rob_id_1), .rob_avail_1(rob_avail_1), .rob_val_1(rob_val_1),
    .get_rob_id_2(get_rob_id_2), .rob_avail_2(rob_avail_2), .rob_val_2(rob_val_2)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    rdy_in = 1'b1; rob_clear = 1'b0; is_commit = 1'b0;
    set_id = '0; set_val = '0; set_from_rob_id = '0;
    set_dep_id = '0; set_dep_Q = '0;
    rs1_id = '0; rs2_id = '0;
    rob_avail_1 = 1'b0; rob_val_1 = '0; rob_avail_2 = 1'b0; rob_val_2 = '0;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic commit(input logic [4:0] id, input logic [31:0] v, input logic [RW-1:0] rob);
    is_commit = 1'b1; set_id = id; set_val = v; set_from_rob_id = rob;
  endtask

  task automatic rename(input logic [4:0] id, input logic [RW-1:0] q);
    set_dep_id = id; set_dep_Q = q;
  endtask

  task automatic expect_rd(input logic op, input logic [31:0] v, input logic hd, input logic [RW-1:0] dep);
    exp_q.push_back({op, hd, v, hd, dep});
  endtask

  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      logic [RW+34:0] e;
      logic [31:0]    a_val;
      logic           a_hd;
      logic [RW-1:0]  a_dep;
      logic [RW-1:0]  a_get;
      logic           bad;
      e     = exp_q.pop_front();
      a_val = e[RW+34] ? rs2_val      : rs1_val;
      a_hd  = e[RW+34] ? rs2_has_dep  : rs1_has_dep;
      a_dep = e[RW+34] ? rs2_dep      : rs1_dep;
      a_get = e[RW+34] ? get_rob_id_2 : get_rob_id_1;
      bad = (a_val != e[RW+32:RW+1]) || (a_hd != e[RW]) ||
            (e[RW+33] && ((a_dep != e[RW-1:0]) || (a_get != e[RW-1:0])));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rs%0d_read t=%0t: got val=%h has_dep=%b dep=%0d get=%0d, want val=%h has_dep=%b dep=%0d",
                 e[RW+34] ? 2 : 1, $time, a_val, a_hd, a_dep, a_get,
                 e[RW+32:RW+1], e[RW], e[RW-1:0]);
      end
    end
  end

  initial begin
    idle();
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rs1_id = 5'd5; rs2_id = 5'd0;
    expect_rd(0, 32'h0, 0, 0);
    expect_rd(1, 32'h0, 0, 0);

    cyc(); rst_in = 1'b1;
    commit(5'd0, 32'hDEAD, 0); rs1_id = 5'd0;
    expect_rd(0, 32'h0, 0, 0);
    cyc(); rs1_id = 5'd0; rs2_id = 5'd5;
    expect_rd(0, 32'h0, 0, 0);
    expect_rd(1, 32'h0, 0, 0);

    // x5 rename; same-cycle read sees the pre-rename state
    cyc(); rename(5'd5, 3); rs1_id = 5'd5;
    expect_rd(0, 32'h0, 0, 0);
    cyc(); rs1_id = 5'd5; rs2_id = 5'd5; rob_avail_2 = 1'b1; rob_val_2 = 32'h55;
    expect_rd(0, 32'h0, 1, 3);
    expect_rd(1, 32'h55, 0, 0);
    cyc(); rs1_id = 5'd5; rob_avail_1 = 1'b1; rob_val_1 = 32'h55;
    expect_rd(0, 32'h55, 0, 0);

    // commit bypass on the matching tag
    cyc(); commit(5'd5, 32'h1234, 3); rs1_id = 5'd5; rs2_id = 5'd5;
    expect_rd(0, 32'h1234, 0, 0);
    expect_rd(1, 32'h1234, 0, 0);
    cyc(); rs1_id = 5'd5;
    expect_rd(0, 32'h1234, 0, 0);

    // stale commit must not clear a newer rename of x7
    cyc(); rename(5'd7, 2);
    cyc(); rename(5'd7, 6);
    cyc(); commit(5'd7, 32'h11, 2); rs1_id = 5'd7;
    expect_rd(0, 32'h0, 1, 6);
    cyc(); rs1_id = 5'd7; rs2_id = 5'd7; rob_avail_2 = 1'b1; rob_val_2 = 32'h77;
    expect_rd(0, 32'h0, 1, 6);
    expect_rd(1, 32'h77, 0, 0);

    // same-cycle commit and rename of x9
    cyc(); rename(5'd9, 4);
    cyc(); commit(5'd9, 32'h99, 4); rename(5'd9, 5); rs1_id = 5'd9;
    expect_rd(0, 32'h99, 0, 0);
    cyc(); rs1_id = 5'd9;
    expect_rd(0, 32'h0, 1, 5);

    // flush with a concurrent commit and rename
    cyc(); commit(5'd1, 32'hA1, 0);
    cyc(); rename(5'd1, 7);
    cyc(); rename(5'd2, 8);
    cyc(); rename(5'd3, 9); rs1_id = 5'd1; rs2_id = 5'd2;
    expect_rd(0, 32'h0, 1, 7);
    expect_rd(1, 32'h0, 1, 8);
    cyc(); rob_clear = 1'b1; commit(5'd1, 32'hBAD, 7); rename(5'd3, 2); rs1_id = 5'd2; rs2_id = 5'd3;
    expect_rd(0, 32'h0, 1, 8);
    expect_rd(1, 32'h0, 1, 9);
    cyc(); rs1_id = 5'd1; rs2_id = 5'd2;
    expect_rd(0, 32'hA1, 0, 0);
    expect_rd(1, 32'h0, 0, 0);
    cyc(); rs1_id = 5'd3; rs2_id = 5'd7;
    expect_rd(0, 32'h0, 0, 0);
    expect_rd(1, 32'h11, 0, 0);
    cyc(); rs1_id = 5'd9; rs2_id = 5'd5;
    expect_rd(0, 32'h99, 0, 0);
    expect_rd(1, 32'h1234, 0, 0);

    // rdy_in low freezes state
    cyc(); rdy_in = 1'b0; commit(5'd4, 32'h44, 0); rename(5'd6, 3);
    cyc(); rs1_id = 5'd4; rs2_id = 5'd6;
    expect_rd(0, 32'h0, 0, 0);
    expect_rd(1, 32'h0, 0, 0);

    // asynchronous reset mid-operation
    cyc(); rename(5'd8, 5);
    cyc(); rs1_id = 5'd8; rs2_id = 5'd5;
    expect_rd(0, 32'h0, 1, 5);
    expect_rd(1, 32'h1234, 0, 0);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (rs1_has_dep !== 1'b0 || rs2_val !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got rs1_has_dep=%b rs2_val=%h, want 0 and 00000000", rs1_has_dep, rs2_val);
    end
    cyc(); rs1_id = 5'd8; rs2_id = 5'd9;
    expect_rd(0, 32'h0, 0, 0);
    expect_rd(1, 32'h0, 0, 0);

    cyc();
    @(negedge clk_in);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected reads left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
